// File: rtl/lsu_stage.sv
// Load/store stage between EX and writeback: issues one data-memory access at a time,
// forms byte enables and lane-replicated store data, and extracts/extends load results.
module lsu_stage #(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mem_ren,
    input  logic                mem_wen,
    input  logic [2:0]          funct3,
    input  logic [DATA_LEN-1:0] alu_out,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [4:0]          rd_addr,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_LEN-1:0] dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [DATA_LEN-1:0] dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DATA_LEN-1:0] dmem_rdata,
    output logic                out_valid,
    output logic                out_we,
    output logic [4:0]          out_rd,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_fault
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t              state_q, state_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [DATA_LEN-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]          dmem_be_q, dmem_be_d;
    logic [DATA_LEN-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [2:0]          ld_f3_q, ld_f3_d;
    logic [1:0]          ld_off_q, ld_off_d;
    logic [4:0]          rd_q, rd_d;
    logic                out_valid_q, out_valid_d;
    logic                out_we_q, out_we_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [DATA_LEN-1:0] out_data_q, out_data_d;
    logic                out_fault_q, out_fault_d;

    logic                accept;
    logic                is_mem;
    logic                fault;
    logic [3:0]          be_calc;
    logic [DATA_LEN-1:0] wdata_calc;
    logic [DATA_LEN-1:0] rshift;
    logic [DATA_LEN-1:0] load_data;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mem   = mem_ren || mem_wen;

    assign fault = (mem_ren && mem_wen)
                || (mem_ren && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
                || (mem_wen && (funct3 >= 3'd3))
                || (is_mem && funct3[1:0] == 2'd1 && alu_out[0])
                || (is_mem && funct3[1:0] == 2'd2 && alu_out[1:0] != 2'b00);

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        if (mem_wen) begin
            case (funct3[1:0])
                2'd0: begin
                    be_calc    = 4'b0001 << alu_out[1:0];
                    wdata_calc = DATA_LEN'({4{wdata[7:0]}});
                end
                2'd1: begin
                    be_calc    = 4'b0011 << alu_out[1:0];
                    wdata_calc = DATA_LEN'({2{wdata[15:0]}});
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = wdata;
                end
            endcase
        end
    end

    // Move the addressed lane down to bit 0, then size/extend by the latched funct3.
    assign rshift = dmem_rdata >> {ld_off_q, 3'b000};

    always_comb begin
        case (ld_f3_q)
            3'd0:    load_data = {{(DATA_LEN-8){rshift[7]}}, rshift[7:0]};
            3'd1:    load_data = {{(DATA_LEN-16){rshift[15]}}, rshift[15:0]};
            3'd4:    load_data = {{(DATA_LEN-8){1'b0}}, rshift[7:0]};
            3'd5:    load_data = {{(DATA_LEN-16){1'b0}}, rshift[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        ld_f3_d      = ld_f3_q;
        ld_off_d     = ld_off_q;
        rd_d         = rd_q;
        out_valid_d  = 1'b0;
        out_we_d     = 1'b0;
        out_fault_d  = 1'b0;
        out_rd_d     = out_rd_q;
        out_data_d   = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        out_valid_d = 1'b1;
                        out_we_d    = 1'b1;
                        out_rd_d    = rd_addr;
                        out_data_d  = alu_out;
                    end else if (fault) begin
                        out_valid_d = 1'b1;
                        out_fault_d = 1'b1;
                        out_rd_d    = rd_addr;
                        out_data_d  = '0;
                    end else begin
                        state_d      = REQ;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_wen;
                        dmem_addr_d  = {alu_out[DATA_LEN-1:2], 2'b00};
                        dmem_be_d    = be_calc;
                        dmem_wdata_d = wdata_calc;
                        ld_f3_d      = funct3;
                        ld_off_d     = alu_out[1:0];
                        rd_d         = rd_addr;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (dmem_we_q) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b1;
                        out_rd_d    = rd_q;
                        out_data_d  = '0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    out_we_d    = 1'b1;
                    out_rd_d    = rd_q;
                    out_data_d  = load_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= '0;
            ld_f3_q      <= 3'd0;
            ld_off_q     <= 2'd0;
            rd_q         <= 5'd0;
            out_valid_q  <= 1'b0;
            out_we_q     <= 1'b0;
            out_rd_q     <= 5'd0;
            out_data_q   <= '0;
            out_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            ld_f3_q      <= ld_f3_d;
            ld_off_q     <= ld_off_d;
            rd_q         <= rd_d;
            out_valid_q  <= out_valid_d;
            out_we_q     <= out_we_d;
            out_rd_q     <= out_rd_d;
            out_data_q   <= out_data_d;
            out_fault_q  <= out_fault_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign out_valid  = out_valid_q;
    assign out_we     = out_we_q;
    assign out_rd     = out_rd_q;
    assign out_data   = out_data_q;
    assign out_fault  = out_fault_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: each task drives one scenario and checks outputs
// one time unit after the rising edge against hand-computed values.
module tb_lsu_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [4:0]  rd_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_fault;

    int errors = 0;
    int checks = 0;

    lsu_stage #(.DATA_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
        .alu_out(alu_out), .wdata(wdata), .rd_addr(rd_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd),
        .out_data(out_data), .out_fault(out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        in_valid = 1'b1; mem_ren = ren; mem_wen = wen; funct3 = f3;
        alu_out = addr; wdata = wd; rd_addr = rd;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; funct3 = 3'd0;
        alu_out = '0; wdata = '0; rd_addr = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        rst = 1'b1;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if ({dmem_req, out_valid, out_we, out_fault, dmem_we} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {dmem_req, out_valid, out_we, out_fault, dmem_we}); end
        checks++; if ({dmem_addr, dmem_wdata, out_data} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {dmem_addr, dmem_wdata, out_data}); end
        checks++; if ({dmem_be, out_rd} !== 9'h0) begin errors++; $display("FAIL reset_be_rd: got %h expected 0", {dmem_be, out_rd}); end
        rst = 1'b0;
        tick();
        $display("reset: in_ready=%b dmem_req=%b out_valid=%b", in_ready, dmem_req, out_valid);
    endtask

    task automatic test_nonmem();
        drive(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        idle_inputs();
        checks++; if ({out_valid, out_we, out_fault} !== 3'b110) begin errors++; $display("FAIL nonmem_flags: got %b expected 110", {out_valid, out_we, out_fault}); end
        checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL nonmem_rd: got %0d expected 5", out_rd); end
        checks++; if (out_data !== 32'h0000_1234) begin errors++; $display("FAIL nonmem_data: got %h expected 00001234", out_data); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL nonmem_req: got %b expected 0", dmem_req); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nonmem_pulse: got %b expected 0", out_valid); end
        $display("nonmem: rd=5 data=%h", 32'h0000_1234);
    endtask

    task automatic test_store_sb();
        int req_cycles = 0;
        int unstable = 0;
        drive(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd0);
        tick();
        idle_inputs();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sb_in_ready: got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            if (dmem_req) req_cycles++;
            if (dmem_addr !== 32'h100 || dmem_be !== 4'b1000 || dmem_wdata !== 32'hABABABAB || dmem_we !== 1'b1)
                unstable++;
            if (out_valid) unstable++;
            dmem_gnt = (i == 2);
            tick();
        end
        dmem_gnt = 1'b0;
        checks++; if (req_cycles !== 3) begin errors++; $display("FAIL sb_req_cycles: got %0d expected 3", req_cycles); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL sb_req_fields: got %0d bad cycles expected 0 (addr=%h be=%b wd=%h)", unstable, dmem_addr, dmem_be, dmem_wdata); end
        checks++; if ({dmem_req, out_valid, out_we, out_fault} !== 4'b0100) begin errors++; $display("FAIL sb_done: got %b expected 0100", {dmem_req, out_valid, out_we, out_fault}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sb_idle: got %b expected 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sb_pulse: got %b expected 0", out_valid); end
        $display("store SB: addr=%h be=1000 wdata=ABABABAB", 32'h100);
    endtask

    task automatic do_load(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp, input logic [4:0] rd);
        drive(1'b1, 1'b0, f3, addr, 32'h0, rd);
        tick();
        idle_inputs();
        checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'b101111) begin errors++; $display("FAIL %s_req: got %b expected 101111", nm, {dmem_req, dmem_we, dmem_be}); end
        checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s_addr: got %h expected %h", nm, dmem_addr, {addr[31:2], 2'b00}); end
        // rvalid alongside gnt arrives outside WAIT and must be ignored
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        checks++; if ({dmem_req, out_valid, in_ready} !== 3'b000) begin errors++; $display("FAIL %s_wait: got %b expected 000", nm, {dmem_req, out_valid, in_ready}); end
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0;
        checks++; if ({out_valid, out_we, out_fault} !== 3'b110) begin errors++; $display("FAIL %s_flags: got %b expected 110", nm, {out_valid, out_we, out_fault}); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", nm, out_data, exp); end
        checks++; if (out_rd !== rd) begin errors++; $display("FAIL %s_rd: got %0d expected %0d", nm, out_rd, rd); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_pulse: got %b expected 0", nm, out_valid); end
        $display("load %s: addr=%h rdata=%h data=%h", nm, addr, rdata, exp);
    endtask

    task automatic test_loads();
        do_load("lb",  3'd0, 32'h102, 32'h0080_0000, 32'hFFFF_FF80, 5'd7);
        do_load("lbu", 3'd4, 32'h102, 32'h0080_0000, 32'h0000_0080, 5'd8);
        do_load("lh",  3'd1, 32'h102, 32'h8001_0000, 32'hFFFF_8001, 5'd9);
        do_load("lhu", 3'd5, 32'h100, 32'h1234_F00D, 32'h0000_F00D, 5'd0);
        do_load("lw",  3'd2, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd31);
    endtask

    logic [2:0]  flt_f3   [4] = '{3'd2, 3'd1, 3'd3, 3'd0};
    logic        flt_ren  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        flt_wen  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] flt_addr [4] = '{32'h101, 32'h101, 32'h100, 32'h100};

    task automatic test_fault();
        for (int i = 0; i < 4; i++) begin
            drive(flt_ren[i], flt_wen[i], flt_f3[i], flt_addr[i], 32'hFFFF_FFFF, 5'd3);
            tick();
            idle_inputs();
            checks++; if ({dmem_req, out_valid, out_fault, out_we, in_ready} !== 5'b01101) begin errors++; $display("FAIL fault%0d_flags: got %b expected 01101", i, {dmem_req, out_valid, out_fault, out_we, in_ready}); end
            checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL fault%0d_data: got %h expected 0", i, out_data); end
            tick();
            checks++; if ({out_valid, dmem_req} !== 2'b00) begin errors++; $display("FAIL fault%0d_after: got %b expected 00", i, {out_valid, dmem_req}); end
            $display("fault %0d: ren=%b wen=%b f3=%0d addr=%h", i, flt_ren[i], flt_wen[i], flt_f3[i], flt_addr[i]);
        end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd4);
        tick();
        idle_inputs();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst = 1'b1;
        #2;
        checks++; if ({in_ready, dmem_req, out_valid} !== 3'b100) begin errors++; $display("FAIL abort_async: got %b expected 100", {in_ready, dmem_req, out_valid}); end
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        tick();
        dmem_rvalid = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL abort_wait: got %b expected 01", {out_valid, in_ready}); end
        // abandon a store still in REQ; the late grant must not produce a result
        drive(1'b0, 1'b1, 3'd2, 32'h300, 32'h1234_5678, 5'd0);
        tick();
        idle_inputs();
        rst = 1'b1; #2; rst = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        checks++; if ({out_valid, in_ready, dmem_req} !== 3'b010) begin errors++; $display("FAIL abort_req: got %b expected 010", {out_valid, in_ready, dmem_req}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_late: got %b expected 0", out_valid); end
        $display("reset abort: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 3'd0, 32'h11, 32'h0, 5'd1);
        tick();
        drive(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 5'd2);
        checks++; if ({out_valid, out_rd, out_data} !== {1'b1, 5'd1, 32'h11}) begin errors++; $display("FAIL b2b_first: got %b/%0d/%h expected 1/1/00000011", out_valid, out_rd, out_data); end
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'h33, 32'h0, 5'd3);
        checks++; if ({in_ready, out_valid, dmem_req} !== 3'b001) begin errors++; $display("FAIL b2b_req: got %b expected 001", {in_ready, out_valid, dmem_req}); end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL b2b_wait: got %b expected 00", {in_ready, out_valid}); end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        checks++; if ({out_valid, out_we, out_rd, out_data} !== {2'b11, 5'd2, 32'hCAFE_F00D}) begin errors++; $display("FAIL b2b_second: got %b%b/%0d/%h expected 11/2/cafef00d", out_valid, out_we, out_rd, out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        tick();
        idle_inputs();
        checks++; if ({out_valid, out_we, out_rd, out_data} !== {2'b11, 5'd3, 32'h33}) begin errors++; $display("FAIL b2b_third: got %b%b/%0d/%h expected 11/3/00000033", out_valid, out_we, out_rd, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", out_valid); end
        $display("back-to-back: nonmem rd1, lw rd2, nonmem rd3");
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_store_sb();
        test_loads();
        test_fault();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
